// File: rtl/pc_select_pkg.sv
// Shared types and helpers for the fetch-stage PC select register.
// Holds the redirect-buffer state encoding, the sequential select code and the alignment-mask helper.
package pc_select_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam int unsigned SEL_SEQ = 0;

   // Mask of the low address bits that must be zero; callers truncate to their width.
   function automatic logic [63:0] align_mask(input int unsigned align);
      return (64'd1 << align) - 64'd1;
   endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Combinational N-way select over a flattened bus; input i occupies bits [i*WIDTH +: WIDTH].
// An out-of-range select drives zero and raises range_err instead of producing X.
module mux_n_to_1 #(
   parameter int WIDTH = 32,
   parameter int N     = 2,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N*WIDTH-1:0] data_flat,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   data,
   output logic               range_err
);

   // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      data      = '0;
      range_err = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (sel == SEL_W'(i)) begin
            data      = data_flat[i*WIDTH +: WIDTH];
            range_err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pc_select_reg.sv
// Program-counter register with N-way next-PC select, stall handling and a one-deep redirect buffer.
// A redirect requested while stalled is held in PEND and applied on the first unstalled edge.
module pc_select_reg
   import pc_select_pkg::*;
#(
   parameter int                  WIDTH    = 32,
   parameter int                  NUM_TGT  = 4,
   parameter int                  SEL_W    = $clog2(NUM_TGT + 1),
   parameter int                  STEP     = 4,
   parameter int                  ALIGN    = 2,
   parameter logic [WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_TGT*WIDTH-1:0] tgt_flat,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     stall,
   output logic [WIDTH-1:0]         pc,
   output logic [WIDTH-1:0]         link,
   output logic                     redirect,
   output logic                     misalign,
   output logic                     sel_err
);

   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(align_mask(ALIGN));
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   state_t           state;
   logic [WIDTH-1:0] pend_addr;
   logic             pend_mis;

   logic [WIDTH-1:0] seq;
   logic [WIDTH-1:0] mux_out;
   logic             sel_oor;
   logic [WIDTH-1:0] tgt;
   logic             mis;
   logic             is_tgt;

   assign seq    = pc + STEP_W;
   assign tgt    = mux_out & ~LOW_MASK;
   assign mis    = |(mux_out & LOW_MASK);
   assign is_tgt = !sel_oor && (sel != SEL_W'(SEL_SEQ));

   mux_n_to_1 #(
      .WIDTH (WIDTH),
      .N     (NUM_TGT + 1),
      .SEL_W (SEL_W)
   ) u_mux (
      .data_flat (({tgt_flat, seq})),
      .sel       (sel),
      .data      (mux_out),
      .range_err (sel_oor)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         link      <= RESET_PC + STEP_W;
         redirect  <= 1'b0;
         misalign  <= 1'b0;
         sel_err   <= 1'b0;
         state     <= IDLE;
         pend_addr <= '0;
         pend_mis  <= 1'b0;
      end else begin
         redirect <= 1'b0;
         misalign <= 1'b0;
         if (sel_oor) begin
            // Illegal select freezes everything, including a pending release.
            sel_err <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (!stall) begin
                     if (is_tgt) begin
                        pc       <= tgt;
                        link     <= tgt + STEP_W;
                        redirect <= 1'b1;
                        misalign <= mis;
                     end else begin
                        pc   <= seq;
                        link <= seq + STEP_W;
                     end
                  end else if (is_tgt) begin
                     pend_addr <= tgt;
                     pend_mis  <= mis;
                     state     <= PEND;
                  end
               end
               PEND: begin
                  if (stall) begin
                     if (is_tgt) begin
                        pend_addr <= tgt;
                        pend_mis  <= mis;
                     end
                  end else begin
                     pc       <= pend_addr;
                     link     <= pend_addr + STEP_W;
                     redirect <= 1'b1;
                     misalign <= pend_mis;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_select_reg.sv
// Self-checking bench for pc_select_reg: directed scenarios plus randomized traffic
// compared against a behavioural model of the PC, redirect buffer and error flag.
module tb_pc_select_reg;

   localparam int WIDTH   = 32;
   localparam int NUM_TGT = 4;
   localparam int SEL_W   = 3;
   localparam int STEP    = 4;
   localparam int ALIGN   = 2;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_TGT*WIDTH-1:0] tgt_flat;
   logic [SEL_W-1:0]         sel;
   logic                     stall;
   logic [WIDTH-1:0]         pc;
   logic [WIDTH-1:0]         link;
   logic                     redirect;
   logic                     misalign;
   logic                     sel_err;

   int total = 0;
   int bad   = 0;

   // Reference model state
   longint unsigned m_pc;
   bit              m_pend;
   longint unsigned m_pend_addr;
   bit              m_pend_mis;
   bit              m_err;
   bit              m_redir;
   bit              m_mis;

   pc_select_reg #(
      .WIDTH    (WIDTH),
      .NUM_TGT  (NUM_TGT),
      .SEL_W    (SEL_W),
      .STEP     (STEP),
      .ALIGN    (ALIGN),
      .RESET_PC ('0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tgt_flat (tgt_flat),
      .sel      (sel),
      .stall    (stall),
      .pc       (pc),
      .link     (link),
      .redirect (redirect),
      .misalign (misalign),
      .sel_err  (sel_err)
   );

   always #5 clk = ~clk;

   function automatic longint unsigned target_of(input int k);
      return longint'(tgt_flat[k*WIDTH +: WIDTH]);
   endfunction

   function automatic longint unsigned m_link();
      return (m_pc + STEP) % (64'd1 << WIDTH);
   endfunction

   // Advance one clock and update the model from the inputs that were applied.
   task automatic step();
      longint unsigned t;
      longint unsigned gran;
      int s;
      s    = int'(sel);
      gran = 64'd1 << ALIGN;
      @(posedge clk);
      if (!rst_n) begin
         m_pc = 0; m_pend = 0; m_pend_addr = 0; m_pend_mis = 0;
         m_err = 0; m_redir = 0; m_mis = 0;
      end else begin
         m_redir = 0;
         m_mis   = 0;
         t = (s >= 1 && s <= NUM_TGT) ? target_of(s - 1) : 0;
         if (s > NUM_TGT) begin
            m_err = 1;
         end else if (m_pend) begin
            if (stall) begin
               if (s != 0) begin
                  m_pend_addr = (t / gran) * gran;
                  m_pend_mis  = (t % gran) != 0;
               end
            end else begin
               m_pc = m_pend_addr; m_redir = 1; m_mis = m_pend_mis; m_pend = 0;
            end
         end else if (!stall) begin
            if (s == 0) begin
               m_pc = (m_pc + STEP) % (64'd1 << WIDTH);
            end else begin
               m_pc = (t / gran) * gran; m_redir = 1; m_mis = (t % gran) != 0;
            end
         end else if (s != 0) begin
            m_pend = 1;
            m_pend_addr = (t / gran) * gran;
            m_pend_mis  = (t % gran) != 0;
         end
      end
      #1;
   endtask

   task automatic load_pc(input logic [WIDTH-1:0] addr);
      stall = 1'b0;
      sel   = 3'd1;
      tgt_flat[0 +: WIDTH] = addr;
      step();
      sel = 3'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; sel = 3'd0; tgt_flat = '0;
      step(); step();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
      total++; if (link !== 32'h4) begin bad++; $display("FAIL reset_link got %h exp %h", link, 32'h4); end
      total++; if ({redirect, misalign, sel_err} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got %b exp 000", {redirect, misalign, sel_err});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      sel = 3'd0; stall = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         total++; if (pc !== WIDTH'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got %h exp %h", i, pc, 4 * i); end
         total++; if (link !== WIDTH'(4 * i + 4)) begin bad++; $display("FAIL seq_link%0d got %h exp %h", i, link, 4 * i + 4); end
         total++; if (redirect !== 1'b0) begin bad++; $display("FAIL seq_redirect%0d got %b exp 0", i, redirect); end
      end
   endtask

   task automatic test_redirect();
      load_pc(32'h100);
      tgt_flat[WIDTH +: WIDTH] = 32'h2000;
      sel = 3'd2;
      step();
      total++; if (pc !== 32'h2000) begin bad++; $display("FAIL redir_pc got %h exp 2000", pc); end
      total++; if (link !== 32'h2004) begin bad++; $display("FAIL redir_link got %h exp 2004", link); end
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL redir_pulse got %b exp 1", redirect); end
      sel = 3'd0;
      step();
      total++; if (pc !== 32'h2004) begin bad++; $display("FAIL redir_next_pc got %h exp 2004", pc); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL redir_pulse_end got %b exp 0", redirect); end
   endtask

   task automatic test_stall_pending();
      load_pc(32'h40);
      stall = 1'b1; sel = 3'd1;
      tgt_flat[0 +: WIDTH] = 32'h500;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) tgt_flat[0 +: WIDTH] = 32'h600;
         step();
         total++; if (pc !== 32'h40 || redirect !== 1'b0) begin
            bad++; $display("FAIL stall_hold%0d got pc=%h redir=%b exp pc=40 redir=0", i, pc, redirect);
         end
      end
      stall = 1'b0; sel = 3'd0;
      step();
      total++; if (pc !== 32'h600) begin bad++; $display("FAIL pend_release_pc got %h exp 600", pc); end
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL pend_release_pulse got %b exp 1", redirect); end
      step();
      total++; if (pc !== 32'h604 || redirect !== 1'b0) begin
         bad++; $display("FAIL pend_after got pc=%h redir=%b exp pc=604 redir=0", pc, redirect);
      end
   endtask

   task automatic test_sel_err();
      load_pc(32'h80);
      sel = 3'd5;
      step();
      total++; if (pc !== 32'h80) begin bad++; $display("FAIL selerr_pc got %h exp 80", pc); end
      total++; if (sel_err !== 1'b1 || redirect !== 1'b0) begin
         bad++; $display("FAIL selerr_flag got err=%b redir=%b exp err=1 redir=0", sel_err, redirect);
      end
      sel = 3'd0;
      step(); step();
      total++; if (sel_err !== 1'b1 || pc !== 32'h88) begin
         bad++; $display("FAIL selerr_sticky got err=%b pc=%h exp err=1 pc=88", sel_err, pc);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL selerr_clear got %b exp 0", sel_err); end
   endtask

   task automatic test_misalign_wrap();
      tgt_flat[0 +: WIDTH] = 32'h1003;
      sel = 3'd1; stall = 1'b0;
      step();
      total++; if (pc !== 32'h1000) begin bad++; $display("FAIL mis_pc got %h exp 1000", pc); end
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_pulse got %b exp 1", misalign); end
      sel = 3'd0;
      step();
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_pulse_end got %b exp 0", misalign); end
      load_pc(32'hFFFF_FFFC);
      total++; if (link !== 32'h0) begin bad++; $display("FAIL wrap_link got %h exp 0", link); end
      step();
      total++; if (pc !== 32'h0 || link !== 32'h4) begin
         bad++; $display("FAIL wrap_pc got pc=%h link=%h exp pc=0 link=4", pc, link);
      end
   endtask

   task automatic test_reset_pending();
      load_pc(32'h300);
      stall = 1'b1; sel = 3'd1;
      tgt_flat[0 +: WIDTH] = 32'h700;
      step();
      total++; if (pc !== 32'h300) begin bad++; $display("FAIL rstpend_hold got %h exp 300", pc); end
      rst_n = 1'b0;
      step();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL rstpend_pc got %h exp 0", pc); end
      rst_n = 1'b1; stall = 1'b0; sel = 3'd0;
      step();
      total++; if (pc !== 32'h4 || redirect !== 1'b0) begin
         bad++; $display("FAIL rstpend_after got pc=%h redir=%b exp pc=4 redir=0", pc, redirect);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < NUM_TGT; k++) tgt_flat[k*WIDTH +: WIDTH] = $urandom;
         stall = ($urandom_range(0, 2) == 0);
         sel   = ($urandom_range(0, 19) == 0) ? SEL_W'($urandom_range(5, 7))
                                              : SEL_W'($urandom_range(0, NUM_TGT));
         rst_n = ($urandom_range(0, 49) != 0);
         step();
         total++; if (pc !== WIDTH'(m_pc)) begin bad++; $display("FAIL rnd_pc@%0d got %h exp %h", n, pc, WIDTH'(m_pc)); end
         total++; if (link !== WIDTH'(m_link())) begin bad++; $display("FAIL rnd_link@%0d got %h exp %h", n, link, WIDTH'(m_link())); end
         total++; if (redirect !== m_redir) begin bad++; $display("FAIL rnd_redirect@%0d got %b exp %b", n, redirect, m_redir); end
         total++; if (misalign !== m_mis) begin bad++; $display("FAIL rnd_misalign@%0d got %b exp %b", n, misalign, m_mis); end
         total++; if (sel_err !== m_err) begin bad++; $display("FAIL rnd_sel_err@%0d got %b exp %b", n, sel_err, m_err); end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; sel = '0; tgt_flat = '0;
      m_pc = 0; m_pend = 0; m_pend_addr = 0; m_pend_mis = 0;
      m_err = 0; m_redir = 0; m_mis = 0;
      test_reset();
      test_sequential();
      test_redirect();
      test_stall_pending();
      test_sel_err();
      test_misalign_wrap();
      test_reset_pending();
      test_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
